// File: rtl/line_buf_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : line_buf_sequencer_if
// Description : Write-strobe, readout and status bundle of the line buffer sequencer.
//               The _i/_o suffixes are named from the sequencer's side.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_buf_sequencer_if #(
  parameter int PIX_W = 10
);
  logic             line_start_i;
  logic             pix_strobe_i;
  logic             bufer_in_en_o;
  logic             start_write_o;
  logic             bufer_change_o;
  logic [PIX_W-1:0] pix_out_o;
  logic             rd_valid_o;
  logic             rd_ready_i;
  logic             line_busy_o;
  logic [7:0]       row_cnt_o;
  logic             frame_end_o;
  logic [1:0]       err_o;
  logic             clr_err_i;

  modport master (
    output line_start_i, pix_strobe_i, rd_ready_i, clr_err_i,
    input  bufer_in_en_o, start_write_o, bufer_change_o, pix_out_o, rd_valid_o,
           line_busy_o, row_cnt_o, frame_end_o, err_o
  );

  modport slave (
    input  line_start_i, pix_strobe_i, rd_ready_i, clr_err_i,
    output bufer_in_en_o, start_write_o, bufer_change_o, pix_out_o, rd_valid_o,
           line_busy_o, row_cnt_o, frame_end_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/line_buf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : line_buf_sequencer
// Description : Ping-pong line buffer sequencer; fills one bank from the ADC while
//               the other bank's finished line is walked out to pixel readout.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buf_sequencer #(
  parameter int PIX_IN_ROW = 320,
  parameter int CHANNELS   = 2,
  parameter int ROWS       = 240,
  parameter int PIX_W      = 10,
  parameter int RD_LAT     = 2
) (
  input  wire logic           clk_i,
  input  wire logic           reset_n_i,
  line_buf_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ARM  = 2'd1,
    W_FILL = 2'd2,
    W_DONE = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_RUN   = 2'd1,
    R_DRAIN = 2'd2
  } rd_state_e;

  localparam int               c_half       = PIX_IN_ROW / CHANNELS;
  localparam int               c_dw         = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [PIX_W-1:0] c_wcnt_last  = PIX_W'(c_half - 1);
  localparam logic [PIX_W-1:0] c_pix_last   = PIX_W'(PIX_IN_ROW - 1);
  localparam logic [c_dw-1:0]  c_drain_last = c_dw'(RD_LAT - 1);
  localparam logic [7:0]       c_row_last   = 8'(ROWS - 1);

  wr_state_e         wr_q, wr_d;
  rd_state_e         rd_q, rd_d;
  logic [PIX_W-1:0]  wcnt_q, wcnt_d;
  logic              pend_q, pend_d;
  logic              bank_q, bank_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [c_dw-1:0]   drain_q, drain_d;
  logic [7:0]        row_q, row_d;
  logic              frame_q, frame_d;
  logic [1:0]        err_q, err_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              w_issue;
  logic              w_swap;
  logic              w_rd_free;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_q    <= W_IDLE;
      rd_q    <= R_IDLE;
      wcnt_q  <= '0;
      pend_q  <= 1'b0;
      bank_q  <= 1'b0;
      pix_q   <= '0;
      drain_q <= '0;
      row_q   <= '0;
      frame_q <= 1'b0;
      err_q   <= '0;
      vld_q   <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;
      bank_q  <= bank_d;
      pix_q   <= pix_d;
      drain_q <= drain_d;
      row_q   <= row_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    wcnt_d    = wcnt_q;
    pend_d    = pend_q;
    bank_d    = bank_q;
    pix_d     = pix_q;
    drain_d   = drain_q;
    row_d     = row_q;
    frame_d   = 1'b0;
    err_d     = bus.clr_err_i ? 2'b00 : err_q;
    w_issue   = 1'b0;
    w_swap    = 1'b0;
    // The read side can take a new line while idle or in its very last drain clock.
    w_rd_free = (rd_q == R_IDLE) || ((rd_q == R_DRAIN) && (drain_q == c_drain_last));

    case (wr_q)
      W_IDLE: begin
        if (bus.line_start_i || pend_q) begin
          wr_d   = W_ARM;
          pend_d = 1'b0;
        end
      end
      W_ARM: begin
        wcnt_d = '0;
        wr_d   = W_FILL;
      end
      W_FILL: begin
        if (bus.line_start_i) begin
          err_d[1] = 1'b1;
          wr_d     = W_ARM;
        end else if (bus.pix_strobe_i) begin
          wcnt_d = wcnt_q + PIX_W'(1);
          if (wcnt_q == c_wcnt_last) wr_d = W_DONE;
        end
      end
      W_DONE: begin
        if (bus.line_start_i) pend_d = 1'b1;
        if (w_rd_free) begin
          bank_d = ~bank_q;
          w_swap = 1'b1;
        end else begin
          err_d[0] = 1'b1;
        end
        wr_d = W_IDLE;
      end
      default: wr_d = W_IDLE;
    endcase

    case (rd_q)
      R_IDLE: begin
        pix_d = '0;
        if (w_swap) rd_d = R_RUN;
      end
      R_RUN: begin
        if (bus.rd_ready_i) begin
          w_issue = 1'b1;
          if (pix_q == c_pix_last) begin
            pix_d   = '0;
            drain_d = '0;
            rd_d    = R_DRAIN;
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
      end
      R_DRAIN: begin
        if (drain_q == c_drain_last) begin
          rd_d    = w_swap ? R_RUN : R_IDLE;
          row_d   = (row_q == c_row_last) ? 8'd0 : row_q + 8'd1;
          frame_d = (row_q == c_row_last);
        end else begin
          drain_d = drain_q + c_dw'(1);
        end
      end
      default: rd_d = R_IDLE;
    endcase
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_comb vld_d = w_issue;
    end else begin : g_latn
      always_comb vld_d = {vld_q[RD_LAT-2:0], w_issue};
    end
  endgenerate

  assign bus.bufer_in_en_o  = (wr_q == W_FILL);
  assign bus.start_write_o  = (wr_q == W_ARM);
  assign bus.bufer_change_o = bank_q;
  assign bus.pix_out_o      = pix_q;
  assign bus.rd_valid_o     = vld_q[RD_LAT-1];
  assign bus.line_busy_o    = (rd_q != R_IDLE);
  assign bus.row_cnt_o      = row_q;
  assign bus.frame_end_o    = frame_q;
  assign bus.err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_line_buf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_buf_sequencer
// Description : Directed bench: full-size sequencer for line-level scenarios and an
//               8-pixel instance for a complete 240-row frame at maximum line rate.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_buf_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  line_buf_sequencer_if #(.PIX_W(10)) ifa ();
  line_buf_sequencer_if #(.PIX_W(10)) ifb ();

  line_buf_sequencer u_dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (ifa)
  );

  line_buf_sequencer #(.PIX_IN_ROW(8)) u_small (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (ifb)
  );

  always #5 clk = ~clk;

  logic       mon_a = 1'b0;
  logic       mon_b = 1'b0;
  int         vcnt_a;
  int         vcnt_b;
  int         fcnt_b;
  int         tog_b;
  logic       bank_prev_b;

  always @(negedge clk) begin
    bank_prev_b <= ifb.bufer_change_o;
    if (!mon_a) vcnt_a <= 0;
    else if (ifa.rd_valid_o) vcnt_a <= vcnt_a + 1;
    if (!mon_b) begin
      vcnt_b <= 0;
      fcnt_b <= 0;
      tog_b  <= 0;
    end else begin
      if (ifb.rd_valid_o) vcnt_b <= vcnt_b + 1;
      if (ifb.frame_end_o) fcnt_b <= fcnt_b + 1;
      if (ifb.bufer_change_o != bank_prev_b) tog_b <= tog_b + 1;
    end
  end

  logic [9:0] pix_h [0:699];
  logic       val_h [0:699];
  logic       rdy_h [0:699];
  logic       exp_v [0:699];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the write FSM in W_DONE after n strobes of a clean line.
  task automatic fill_line(input int n);
    ifa.line_start_i = 1'b1;
    tick();
    ifa.line_start_i = 1'b0;
    tick();
    ifa.pix_strobe_i = 1'b1;
    repeat (n) tick();
    ifa.pix_strobe_i = 1'b0;
  endtask

  // Entered in the first R_RUN clock; records n clocks and checks against the address model.
  task automatic run_readout(input int n, input bit toggle, input string tag);
    int issued;
    int bad_a;
    int bad_v;
    int nval;
    for (int k = 0; k < n; k++) begin
      ifa.rd_ready_i = toggle ? (k % 2 == 0) : 1'b1;
      rdy_h[k] = ifa.rd_ready_i;
      pix_h[k] = ifa.pix_out_o;
      val_h[k] = ifa.rd_valid_o;
      tick();
    end
    ifa.rd_ready_i = 1'b1;
    issued = 0;
    bad_a  = 0;
    bad_v  = 0;
    nval   = 0;
    for (int k = 0; k < 700; k++) exp_v[k] = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (rdy_h[k] && issued < 320) begin
        if (pix_h[k] != issued[9:0]) bad_a++;
        if (k + 2 < 700) exp_v[k+2] = 1'b1;
        issued++;
      end
    end
    for (int k = 0; k < n; k++) begin
      if (val_h[k] !== exp_v[k]) bad_v++;
      if (val_h[k]) nval++;
    end
    chk({tag, "_addr_seq"}, 32'(bad_a), 32'd0);
    chk({tag, "_valid_timing"}, 32'(bad_v), 32'd0);
    chk({tag, "_valid_count"}, 32'(nval), 32'd320);
  endtask

  initial begin
    int rbad;
    rst_n = 1'b0;
    ifa.line_start_i = 1'b0; ifa.pix_strobe_i = 1'b0; ifa.rd_ready_i = 1'b1; ifa.clr_err_i = 1'b0;
    ifb.line_start_i = 1'b0; ifb.pix_strobe_i = 1'b0; ifb.rd_ready_i = 1'b1; ifb.clr_err_i = 1'b0;
    repeat (3) tick();
    chk("rst_outputs", 32'({ifa.bufer_in_en_o, ifa.start_write_o, ifa.bufer_change_o, ifa.rd_valid_o,
                            ifa.line_busy_o, ifa.frame_end_o, ifa.err_o, ifa.pix_out_o, ifa.row_cnt_o}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean line: arm pulse, fill enable, swap, 320-pixel readout two clocks behind.
    ifa.line_start_i = 1'b1;
    tick();
    ifa.line_start_i = 1'b0;
    chk("t1_start_write", 32'(ifa.start_write_o), 32'd1);
    chk("t1_in_en_arm", 32'(ifa.bufer_in_en_o), 32'd0);
    tick();
    chk("t1_start_write_end", 32'(ifa.start_write_o), 32'd0);
    begin
      int en_cnt;
      en_cnt = 0;
      ifa.pix_strobe_i = 1'b1;
      for (int i = 0; i < 160; i++) begin
        if (ifa.bufer_in_en_o) en_cnt++;
        tick();
      end
      ifa.pix_strobe_i = 1'b0;
      chk("t1_in_en_fill", 32'(en_cnt), 32'd160);
    end
    chk("t1_in_en_done", 32'(ifa.bufer_in_en_o), 32'd0);
    chk("t1_bank_before", 32'(ifa.bufer_change_o), 32'd0);
    tick();
    chk("t1_bank_swap", 32'(ifa.bufer_change_o), 32'd1);
    chk("t1_busy", 32'(ifa.line_busy_o), 32'd1);
    run_readout(340, 1'b0, "t1");
    chk("t1_pix_last", 32'(pix_h[319]), 32'd319);
    chk("t1_pix_wrap", 32'(pix_h[320]), 32'd0);
    chk("t1_first_valid", 32'({val_h[1], val_h[2]}), 32'd1);
    chk("t1_idle", 32'(ifa.line_busy_o), 32'd0);
    chk("t1_row", 32'(ifa.row_cnt_o), 32'd1);

    // Ready toggling every clock.
    fill_line(160);
    tick();
    chk("t2_bank", 32'(ifa.bufer_change_o), 32'd0);
    run_readout(700, 1'b1, "t2");
    chk("t2_row", 32'(ifa.row_cnt_o), 32'd2);

    // Overflow: second line completes while readout sits at pixel 100.
    fill_line(160);
    ifa.rd_ready_i = 1'b0;
    mon_a = 1'b1;
    tick();
    chk("t3_bank_swap", 32'(ifa.bufer_change_o), 32'd1);
    ifa.line_start_i = 1'b1;
    tick();
    ifa.line_start_i = 1'b0;
    tick();
    ifa.pix_strobe_i = 1'b1;
    for (int c = 2; c < 162; c++) begin
      if (c == 62) ifa.rd_ready_i = 1'b1;
      tick();
    end
    ifa.pix_strobe_i = 1'b0;
    chk("t3_pix_at_done", 32'(ifa.pix_out_o), 32'd100);
    tick();
    chk("t3_err_overflow", 32'(ifa.err_o), 32'd1);
    chk("t3_bank_hold", 32'(ifa.bufer_change_o), 32'd1);
    for (int w = 0; w < 400 && ifa.line_busy_o; w++) tick();
    chk("t3_readout_end", 32'(ifa.line_busy_o), 32'd0);
    repeat (3) tick();
    chk("t3_valid_count", 32'(vcnt_a), 32'd320);
    mon_a = 1'b0;
    chk("t3_row", 32'(ifa.row_cnt_o), 32'd3);
    ifa.clr_err_i = 1'b1;
    tick();
    ifa.clr_err_i = 1'b0;
    chk("t3_err_clear", 32'(ifa.err_o), 32'd0);

    // Short line: restart after 50 strobes, counter must restart from zero.
    ifa.line_start_i = 1'b1;
    tick();
    ifa.line_start_i = 1'b0;
    tick();
    ifa.pix_strobe_i = 1'b1;
    repeat (50) tick();
    ifa.pix_strobe_i = 1'b0;
    ifa.line_start_i = 1'b1;
    tick();
    ifa.line_start_i = 1'b0;
    chk("t4_err_short", 32'(ifa.err_o), 32'd2);
    chk("t4_rearm", 32'(ifa.start_write_o), 32'd1);
    tick();
    ifa.pix_strobe_i = 1'b1;
    repeat (159) tick();
    chk("t4_still_filling", 32'(ifa.bufer_in_en_o), 32'd1);
    chk("t4_no_early_swap", 32'(ifa.bufer_change_o), 32'd1);
    tick();
    ifa.pix_strobe_i = 1'b0;
    chk("t4_fill_done", 32'(ifa.bufer_in_en_o), 32'd0);
    tick();
    chk("t4_swap", 32'(ifa.bufer_change_o), 32'd0);
    repeat (330) tick();
    chk("t4_idle", 32'(ifa.line_busy_o), 32'd0);

    // Reset mid-readout, then a LINE_START landing in W_DONE must be kept.
    fill_line(160);
    tick();
    repeat (200) tick();
    chk("t5_pix_before_rst", 32'(ifa.pix_out_o), 32'd200);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_outputs", 32'({ifa.bufer_in_en_o, ifa.start_write_o, ifa.bufer_change_o, ifa.rd_valid_o,
                               ifa.line_busy_o, ifa.frame_end_o, ifa.err_o, ifa.pix_out_o, ifa.row_cnt_o}), 32'd0);
    tick();
    chk("t5_idle_after", 32'({ifa.rd_valid_o, ifa.line_busy_o, ifa.pix_out_o}), 32'd0);
    fill_line(160);
    ifa.line_start_i = 1'b1;
    tick();
    ifa.line_start_i = 1'b0;
    chk("t5_swap", 32'(ifa.bufer_change_o), 32'd1);
    chk("t5_idle_clk", 32'(ifa.start_write_o), 32'd0);
    tick();
    chk("t5_latched_start", 32'(ifa.start_write_o), 32'd1);

    // Full frame on the 8-pixel instance, one line every 10 clocks.
    mon_b = 1'b1;
    rbad  = 0;
    for (int l = 0; l < 240; l++) begin
      for (int c = 0; c < 10; c++) begin
        ifb.line_start_i = (c == 0);
        ifb.pix_strobe_i = (c >= 2 && c <= 5);
        if (c == 8 && ifb.row_cnt_o != l[7:0]) rbad++;
        tick();
      end
    end
    ifb.line_start_i = 1'b0;
    ifb.pix_strobe_i = 1'b0;
    repeat (15) tick();
    chk("t6_row_seq", 32'(rbad), 32'd0);
    chk("t6_row_wrap", 32'(ifb.row_cnt_o), 32'd0);
    chk("t6_frame_end", 32'(fcnt_b), 32'd1);
    chk("t6_bank_toggles", 32'(tog_b), 32'd240);
    chk("t6_bank_final", 32'(ifb.bufer_change_o), 32'd0);
    chk("t6_no_err", 32'(ifb.err_o), 32'd0);
    chk("t6_valid_count", 32'(vcnt_b), 32'd1920);
    mon_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
